mux_8to1: RTL and testbench
===========================

# mux_8to1

Eight-input, one-bit-per-lane selector with a combinational output and an optional registered copy. Bit `d[sel]` appears on `y` with zero latency. The same value is captured into `y_q` on the clock when `en` is high. The block serves as a generic datapath select stage in which downstream logic uses either the immediate or the pipelined result.

## Interface
- `WIDTH`, default 1: bits per input lane. `d` carries 8 lanes, and lane *i* occupies `d[i*WIDTH +: WIDTH]`.
- `clk` input, 1 bit: single clock; all registers update on its rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `d` input, 8*WIDTH bits: packed data lanes (lane 0 in the LSBs).
- `sel` input, 3 bits: lane select, binary 0–7.
- `en` input, 1 bit: capture enable for the registered path.
- `y` output, WIDTH bits: combinational selected lane.
- `sel_onehot` output, 8 bits: combinational one-hot decode of `sel`.
- `y_q` output, WIDTH bits: registered selected lane.
- `y_valid` output, 1 bit: high for the cycle after each capture.

## Operation
- `y` = lane `sel` of `d`. The path is purely combinational and needs neither clock nor reset, so it is valid with no clock running.
- With `WIDTH`=1 this reduces to `y = d[sel]`.
- `sel_onehot[k]` = 1 iff `sel == k`; exactly one bit is set for any known `sel`.
- Registered path on each rising `clk` edge:
  - If `rst`: `y_q` ← 0 and `y_valid` ← 0.
  - Else if `en`: `y_q` ← the current `y`, and `y_valid` ← 1.
  - Else: `y_q` holds its value and `y_valid` ← 0.
- All 8 select codes are legal; no code is reserved.
- If `sel` contains X or Z, `y` and `sel_onehot` are X in simulation. There is no defaulting.
- `rst` has no effect on `y` or `sel_onehot`.
- Changing `d` or `sel` while `en`=0 never disturbs `y_q`.

## Timing
- `y` and `sel_onehot` have 0-cycle latency and settle within the same delta after `d` or `sel` change.
- `y_q` has 1-cycle latency: it reflects the `d`/`sel` sampled at the edge where `en`=1.
- `y_valid` is a 1-cycle pulse per capture edge. Back-to-back `en` cycles keep it high continuously.
- Reset values: `y_q`=0 and `y_valid`=0, visible from the first edge with `rst`=1.
- `rst` and `en` asserted on the same edge: `rst` wins.
- `rst` asserted mid-stream: the next edge clears both registers, and any capture pending on that edge is lost.
- No handshake or backpressure exists; a capture occurs on every `en`=1 edge.

## Test plan
- Combinational sweep, no clock: `d`=8'b10101010, `sel` stepped 0→7 with 10 time units per step. Required `y` = 0,1,0,1,0,1,0,1.
- Inverse pattern: `d`=8'b01010101, `sel` stepped 0→7. Required `y` = 1,0,1,0,1,0,1,0. Alongside, `sel_onehot` = 8'b1 << `sel`.
- Registered capture: after reset, apply `d`=8'hF0, `sel`=4, `en`=1 for one edge. Required: `y_q`=1 and `y_valid`=1 on that edge. On the next edge with `en`=0, `y_valid`=0 and `y_q` stays 1.
- Hold: with `en`=0, change `d` to 8'h00 and `sel` to 0. Required: `y_q` stays 1 while `y`=0 immediately.
- Reset priority: `en`=1 and `rst`=1 on the same edge with `d`=8'hFF. Required: `y_q`=0 and `y_valid`=0, while `y`=1 stays unaffected.
- Width: `WIDTH`=4, `d`=32'h76543210, `sel`=5. Required: `y`=4'h5; one edge later with `en`=1, `y_q`=4'h5.

Source files
------------

// File: rtl/mux_8to1_if.sv
// Bundle of the 8-lane select stage signals: lane data, select and capture
// enable in one direction, the immediate and registered results back.
interface mux_8to1_if #(
  parameter int WIDTH = 1
);
  logic [8*WIDTH-1:0] d;
  logic [2:0]         sel;
  logic               en;
  logic [WIDTH-1:0]   y;
  logic [7:0]         sel_onehot;
  logic [WIDTH-1:0]   y_q;
  logic               y_valid;

  modport master (
    output d, sel, en,
    input  y, sel_onehot, y_q, y_valid
  );

  modport slave (
    input  d, sel, en,
    output y, sel_onehot, y_q, y_valid
  );
endinterface

// File: rtl/mux_8to1.sv
// Eight-lane selector: lane `sel` of `d` appears on `y` combinationally and is
// captured into `y_q` on every rising clk edge where `en` is high.
module mux_8to1 #(
  parameter int WIDTH = 1
) (
  input logic        clk,
  input logic        rst,
  mux_8to1_if.slave  bus
);

  logic [WIDTH-1:0] y_comb;
  logic [7:0]       onehot_comb;

  // An X/Z select propagates to X on both outputs; nothing is defaulted.
  // NOTE: every always_comb output gets a value on every path, so no latch forms.
  always_comb begin
    y_comb      = bus.d[bus.sel*WIDTH +: WIDTH];
    onehot_comb = 8'b0000_0001 << bus.sel;
  end

  assign bus.y          = y_comb;
  assign bus.sel_onehot = onehot_comb;

  // Reset takes priority over a capture on the same edge.
  // NOTE: state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.y_q     <= '0;
      bus.y_valid <= 1'b0;
    end else if (bus.en) begin
      bus.y_q     <= y_comb;
      bus.y_valid <= 1'b1;
    end else begin
      bus.y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_8to1.sv
// Directed bench for mux_8to1: combinational sweeps with the clock parked,
// then capture, hold, reset priority, back-to-back capture and a 4-bit lane case.
module tb_mux_8to1;

  logic clk;
  logic clk_run;
  logic rst;

  int n_assert;
  int n_fail;

  mux_8to1_if #(.WIDTH(1)) bus1 ();
  mux_8to1_if #(.WIDTH(4)) bus4 ();

  mux_8to1 #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  mux_8to1 #(.WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  // Clock stays parked low until clk_run is raised.
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_aa;
  logic [7:0] exp_55;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    clk      = 1'b0;
    clk_run  = 1'b0;
    rst      = 1'b0;
    bus1.d   = '0;
    bus1.sel = '0;
    bus1.en  = 1'b0;
    bus4.d   = '0;
    bus4.sel = '0;
    bus4.en  = 1'b0;

    // Hand-computed y per sel (index = sel) for d=AA and d=55.
    exp_aa = 8'b1010_1010;
    exp_55 = 8'b0101_0101;

    // Combinational sweep, no clock running.
    bus1.d = 8'b1010_1010;
    for (int i = 0; i < 8; i++) begin
      bus1.sel = 3'(i);
      #10;
      check($sformatf("sweep_aa_y_sel%0d", i), 32'(bus1.y), 32'(exp_aa[i]));
    end

    bus1.d = 8'b0101_0101;
    for (int i = 0; i < 8; i++) begin
      bus1.sel = 3'(i);
      #10;
      check($sformatf("sweep_55_y_sel%0d", i), 32'(bus1.y), 32'(exp_55[i]));
      check($sformatf("onehot_sel%0d", i), 32'(bus1.sel_onehot), 32'(8'b1 << i));
    end

    // Reset: values visible from the first edge with rst high.
    clk_run = 1'b1;
    rst     = 1'b1;
    tick();
    check("rst_y_q",     32'(bus1.y_q),     32'h0);
    check("rst_y_valid", 32'(bus1.y_valid), 32'h0);
    check("rst_y_q_w4",  32'(bus4.y_q),     32'h0);
    rst = 1'b0;

    // Registered capture: F0, sel 4 -> bit 1.
    bus1.d   = 8'hF0;
    bus1.sel = 3'd4;
    bus1.en  = 1'b1;
    tick();
    check("cap_y_q",     32'(bus1.y_q),     32'h1);
    check("cap_y_valid", 32'(bus1.y_valid), 32'h1);
    bus1.en = 1'b0;
    tick();
    check("post_cap_y_valid", 32'(bus1.y_valid), 32'h0);
    check("post_cap_y_q",     32'(bus1.y_q),     32'h1);

    // Hold: y follows immediately, y_q does not.
    bus1.d   = 8'h00;
    bus1.sel = 3'd0;
    #1;
    check("hold_y", 32'(bus1.y), 32'h0);
    tick();
    check("hold_y_q",     32'(bus1.y_q),     32'h1);
    check("hold_y_valid", 32'(bus1.y_valid), 32'h0);

    // Reset beats enable on the same edge; y is untouched by rst.
    bus1.d  = 8'hFF;
    bus1.en = 1'b1;
    rst     = 1'b1;
    #1;
    check("rstpri_y_before", 32'(bus1.y), 32'h1);
    tick();
    check("rstpri_y_q",     32'(bus1.y_q),     32'h0);
    check("rstpri_y_valid", 32'(bus1.y_valid), 32'h0);
    check("rstpri_y_after", 32'(bus1.y),       32'h1);
    rst = 1'b0;

    // Back-to-back captures keep y_valid high and track each new value.
    bus1.d   = 8'hFF;
    bus1.sel = 3'd7;
    tick();
    check("b2b1_y_q",     32'(bus1.y_q),     32'h1);
    check("b2b1_y_valid", 32'(bus1.y_valid), 32'h1);
    bus1.d   = 8'hFE;
    bus1.sel = 3'd0;
    tick();
    check("b2b2_y_q",     32'(bus1.y_q),     32'h0);
    check("b2b2_y_valid", 32'(bus1.y_valid), 32'h1);
    bus1.en = 1'b0;
    tick();
    check("b2b_end_y_valid", 32'(bus1.y_valid), 32'h0);

    // Four-bit lanes.
    bus4.d   = 32'h7654_3210;
    bus4.sel = 3'd5;
    #1;
    check("w4_y_sel5", 32'(bus4.y), 32'h5);
    bus4.en = 1'b1;
    tick();
    check("w4_y_q_sel5",   32'(bus4.y_q),     32'h5);
    check("w4_y_valid",    32'(bus4.y_valid), 32'h1);
    bus4.en  = 1'b0;
    bus4.sel = 3'd7;
    #1;
    check("w4_y_sel7", 32'(bus4.y), 32'h7);
    bus4.sel = 3'd0;
    #1;
    check("w4_y_sel0", 32'(bus4.y), 32'h0);
    tick();
    check("w4_hold_y_q", 32'(bus4.y_q), 32'h5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "bench timed out");
  end

endmodule
